// File: rtl/carregador_memoria_pkg.sv
// Shared CPU definitions: loader state encoding, bus width defaults and the
// BIOS handoff opcode also decoded by the instruction selector.
package carregador_memoria_pkg;

   localparam int unsigned CM_ADDR_WIDTH = 10;
   localparam int unsigned CM_DATA_WIDTH = 32;

   localparam logic [5:0] OPC_BIOS_HANDOFF = 6'b011000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WRITE,
      ST_FIM,
      ST_ERRO
   } cm_state_t;

endpackage

// File: rtl/carregador_memoria.sv
// Boot loader: copies a program image word by word from the BIOS-side source
// port into instruction memory, then pulses done (or erro on a bad length).
module carregador_memoria
   import carregador_memoria_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = CM_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = CM_DATA_WIDTH,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   tamanho,
   output logic                  src_req,
   output logic [ADDR_WIDTH-1:0] src_addr,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  busy,
   output logic                  done,
   output logic                  erro
);

   // One extra counter bit lets a full 2^ADDR_WIDTH copy reach its length.
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   cm_state_t              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       len_q, len_d;
   logic                   src_req_d, mem_we_d, busy_d, done_d, erro_d;
   logic [ADDR_WIDTH-1:0]  src_addr_d, mem_addr_d;
   logic [DATA_WIDTH-1:0]  mem_data_d;

   // State, counter, latched length and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         len_q    <= '0;
         src_req  <= 1'b0;
         src_addr <= '0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         erro     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         src_req  <= src_req_d;
         src_addr <= src_addr_d;
         mem_we   <= mem_we_d;
         mem_addr <= mem_addr_d;
         mem_data <= mem_data_d;
         busy     <= busy_d;
         done     <= done_d;
         erro     <= erro_d;
      end
   end

   // Next state; outputs are decoded from the next state so they are
   // registered yet line up with the state they belong to.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      mem_addr_d = mem_addr;
      mem_data_d = mem_data;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d = tamanho;
               cnt_d = '0;
               if (tamanho == '0)
                  state_d = ST_FIM;
               else if (tamanho > CNT_W'(MAX_WORDS))
                  state_d = ST_ERRO;
               else
                  state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (src_valid) begin
               mem_data_d = src_data;
               mem_addr_d = ADDR_WIDTH'(BASE_ADDR) + cnt_q[ADDR_WIDTH-1:0];
               state_d    = ST_WRITE;
            end
         end
         ST_WRITE: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == len_q) ? ST_FIM : ST_REQ;
         end
         ST_FIM:  state_d = ST_IDLE;
         ST_ERRO: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      src_req_d  = (state_d == ST_REQ);
      src_addr_d = cnt_d[ADDR_WIDTH-1:0];
      mem_we_d   = (state_d == ST_WRITE);
      busy_d     = (state_d != ST_IDLE);
      done_d     = (state_d == ST_FIM);
      erro_d     = (state_d == ST_ERRO);
   end

endmodule

// File: doc/carregador_memoria.md
Name: carregador_memoria

Overview:
- Boot-time writer that copies a program image from a word-addressed source (BIOS-side storage port) into instruction memory.
- Sits on the write side of instruction memory, upstream of the BIOS/memory instruction selector, which begins fetching from memory once the copy has finished.
- Started by a one-cycle pulse from BIOS-executed control logic.
- Reports completion with a single `done` pulse, or an `erro` pulse on a bad length.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width.
- DATA_WIDTH, 32, instruction word width.
- BASE_ADDR, 0, first destination word address in instruction memory.
- MAX_WORDS, 1024, largest accepted copy length in words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a copy.
- tamanho  input  ADDR_WIDTH+1  number of words to copy; sampled only in the cycle `start` is accepted.
- src_req  output  1  source read request; level signal.
- src_addr  output  ADDR_WIDTH  source word index, counting from 0.
- src_valid  input  1  source data valid; a transfer occurs when src_req && src_valid.
- src_data  input  DATA_WIDTH  source word.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  ADDR_WIDTH  instruction-memory write address.
- mem_data  output  DATA_WIDTH  instruction-memory write data.
- busy  output  1  high from the cycle after `start` is accepted until the cycle after `done` or `erro`.
- done  output  1  one-cycle completion pulse.
- erro  output  1  one-cycle pulse when the length is rejected.

Behaviour:
- Reset (asynchronous, reset=0):
  - State returns to IDLE immediately.
  - All outputs are 0, including src_addr, mem_addr and mem_data.
  - Word counter is cleared.
  - A copy in flight is abandoned; no partial `done` is produced.
- States: IDLE, REQ, WRITE, FIM, ERRO.
- IDLE:
  - On start=1, latch `tamanho` and clear the counter.
  - tamanho==0 -> FIM (done with no writes).
  - tamanho>MAX_WORDS -> ERRO.
  - Otherwise -> REQ.
  - `start` is ignored in every state other than IDLE.
- REQ:
  - src_req=1 and src_addr=counter.
  - Hold here, with the request and address stable, until src_valid=1.
  - In the src_valid cycle, register src_data and go to WRITE.
  - src_valid while src_req=0 is ignored.
- WRITE:
  - For exactly one cycle: mem_we=1, mem_addr=(BASE_ADDR+counter) mod 2^ADDR_WIDTH, mem_data=registered word.
  - Counter increments.
  - If the incremented counter equals the latched length -> FIM; otherwise -> REQ.
  - src_req=0 in WRITE.
- FIM: done=1 for one cycle, then IDLE.
- ERRO: erro=1 for one cycle, then IDLE.
- Timing:
  - Minimum 2 cycles per word, with src_valid returned in the first REQ cycle.
  - N words with zero source latency: done asserts 2N+1 cycles after the start edge.
- Address wrap: destination addresses wrap modulo 2^ADDR_WIDTH; no error is raised for wrap.
- Simultaneous events: start during FIM or ERRO is ignored. The requester must wait for busy=0.
- The counter is ADDR_WIDTH+1 bits wide, so a length of exactly MAX_WORDS=2^ADDR_WIDTH terminates correctly.
- mem_we is never asserted outside WRITE.

Decomposition:
- Shared CPU package holds:
  - state encoding (IDLE/REQ/WRITE/FIM/ERRO);
  - the DATA_WIDTH and ADDR_WIDTH defaults;
  - the BIOS handoff opcode constant 6'b011000, shared with the instruction selector.
- No sub-module; the counter and FSM stay in one file.

Test Plan:
- Reset held, then released, start=1, tamanho=3, src_valid tied to 1, src_data=A0,A1,A2 -> writes at addresses 0,1,2 with data A0,A1,A2 on alternating cycles; done pulses 7 cycles after the start edge; busy falls next cycle.
- tamanho=2, src_valid delayed 3 cycles per word -> src_req held with src_addr stable during the waits; exactly 2 mem_we pulses; done once.
- tamanho=0 -> no mem_we, no src_req; done one cycle after start. tamanho=1025 -> erro pulse, no writes, no done.
- BASE_ADDR=1022, tamanho=4 -> mem_addr sequence 1022, 1023, 0, 1.
- reset driven low mid-copy (after 1 of 4 words) -> outputs 0 immediately, no done; a fresh start afterward copies all 4 words from src_addr 0.
- start pulsed while busy -> ignored; word count and done timing unchanged.
